// File: rtl/unison_rx_pkg.sv
// Shared constants for the digital_unison readout receiver: register offsets,
// CTRL/STATUS bit positions and the packing geometry.
package unison_rx_pkg;

  // Byte offsets inside the 256-byte Wishbone window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_UD_EN   = 1;
  localparam int CTRL_RSTB    = 2;
  localparam int CTRL_CLEAR   = 3;
  localparam int CTRL_IRQ_EN  = 4;
  localparam int CTRL_DIV_LSB = 8;

  // STATUS bit positions
  localparam int ST_LEVEL_LSB = 0;
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_OVF       = 18;
  localparam int ST_UDF       = 19;

  // Eight 4-bit {I,Q} samples make one 32-bit FIFO word
  localparam int SAMPLES_PER_WORD = 8;
  localparam int PACK_W           = $clog2(SAMPLES_PER_WORD);

  // A divider field of zero behaves like one
  function automatic logic [7:0] eff_div(input logic [7:0] div);
    return (div == 8'd0) ? 8'd1 : div;
  endfunction

endpackage

// File: rtl/unison_rx_fifo.sv
// Synchronous first-word fall-through FIFO. A pop frees its slot before a
// push in the same cycle is judged, so a full FIFO accepts push+pop.
// clr flushes the contents and wins over any push or pop that cycle.
module unison_rx_fifo
  import unison_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_L);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/unison_readout_rx.sv
// Receiver for the digital_unison serial readout: generates clk_master,
// packs {I,Q} nibbles sampled on its rising edges into 32-bit words, buffers
// them in a FIFO and exposes CTRL/STATUS/DATA on a Wishbone slave.
//
// Wishbone handshake: a request is cyc & stb & window match. It is accepted
// when no ack was issued the previous cycle; the ack follows one cycle later
// with read data valid in the same cycle. A held strobe is acked every other
// cycle. Accepting a DATA read pops the FIFO so the ack cycle sees the new
// state.
module unison_readout_rx
  import unison_rx_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  DIV_RST   = 8'd4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [1:0]  read_out_I,
  input  logic [1:0]  read_out_Q,
  output logic        clk_master,
  output logic        rstb,
  output logic        ud_en,
  output logic        irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              en_q, en_d;
  logic              ud_en_q, ud_en_d;
  logic              rstb_ctrl_q, rstb_ctrl_d;
  logic              irq_en_q, irq_en_d;
  logic [7:0]        div_q, div_d;
  logic              clear_q, clear_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              clk_m_q, clk_m_d;
  logic [PACK_W-1:0] k_q, k_d;
  logic [31:0]       word_q, word_d;
  logic              rstb_q, ud_out_q, irq_q;

  logic              req, acc, wr, rd;
  logic [7:0]        off;
  logic [7:0]        div_max;
  logic [31:0]       ctrl_rd, status_rd;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]       fifo_dout;
  logic [LW-1:0]     fifo_level;
  logic              unused_ok;

  assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign acc     = req & ~ack_q;
  assign wr      = acc & wbs_we_i;
  assign rd      = acc & ~wbs_we_i;
  assign off     = wbs_adr_i[7:0];
  assign div_max = eff_div(div_q) - 8'd1;

  assign ctrl_rd   = {16'b0, div_q, 3'b0, irq_en_q, 1'b0, rstb_ctrl_q, ud_en_q, en_q};
  assign status_rd = {12'b0, udf_q, ovf_q, fifo_full, fifo_empty, 8'b0, 8'(fifo_level)};

  // Byte selects are not supported and only wbs_dat_i's control bits matter
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i};

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign clk_master = clk_m_q;
  assign rstb       = rstb_q;
  assign ud_en      = ud_out_q;
  assign irq        = irq_q;

  unison_rx_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (clear_q),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (word_d),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register access, sticky flags and FIFO pop decision
  always_comb begin
    ack_d       = acc;
    dat_d       = '0;
    en_d        = en_q;
    ud_en_d     = ud_en_q;
    rstb_ctrl_d = rstb_ctrl_q;
    irq_en_d    = irq_en_q;
    div_d       = div_q;
    clear_d     = 1'b0;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    fifo_pop    = 1'b0;
    if (rd) begin
      case (off)
        OFF_CTRL:   dat_d = ctrl_rd;
        OFF_STATUS: dat_d = status_rd;
        OFF_DATA: begin
          if (fifo_empty) begin
            udf_d = 1'b1;
          end else begin
            dat_d    = fifo_dout;
            fifo_pop = 1'b1;
          end
        end
        default:    dat_d = '0;
      endcase
    end
    if (wr) begin
      if (off == OFF_CTRL) begin
        en_d        = wbs_dat_i[CTRL_EN];
        ud_en_d     = wbs_dat_i[CTRL_UD_EN];
        rstb_ctrl_d = wbs_dat_i[CTRL_RSTB];
        irq_en_d    = wbs_dat_i[CTRL_IRQ_EN];
        div_d       = wbs_dat_i[CTRL_DIV_LSB +: 8];
        clear_d     = wbs_dat_i[CTRL_CLEAR];
      end else if (off == OFF_STATUS) begin
        if (wbs_dat_i[ST_OVF]) ovf_d = 1'b0;
        if (wbs_dat_i[ST_UDF]) udf_d = 1'b0;
      end
    end
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (clear_q) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Clock divider, sampling on clk_master rising edges and word packing
  always_comb begin
    cnt_d     = cnt_q;
    clk_m_d   = clk_m_q;
    k_d       = k_q;
    word_d    = word_q;
    fifo_push = 1'b0;
    if (!en_q) begin
      cnt_d   = '0;
      clk_m_d = 1'b0;
      k_d     = '0;
    end else if (clear_q) begin
      cnt_d = '0;
      k_d   = '0;
    end else if (cnt_q >= div_max) begin
      cnt_d   = '0;
      clk_m_d = ~clk_m_q;
      if (!clk_m_q) begin
        word_d[{k_q, 2'b00} +: 4] = {read_out_I, read_out_Q};
        k_d = k_q + 1'b1;
        if (k_q == PACK_W'(SAMPLES_PER_WORD - 1)) fifo_push = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      en_q        <= 1'b0;
      ud_en_q     <= 1'b0;
      rstb_ctrl_q <= 1'b0;
      irq_en_q    <= 1'b0;
      div_q       <= DIV_RST;
      clear_q     <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      cnt_q       <= '0;
      clk_m_q     <= 1'b0;
      k_q         <= '0;
      word_q      <= '0;
      rstb_q      <= 1'b0;
      ud_out_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      en_q        <= en_d;
      ud_en_q     <= ud_en_d;
      rstb_ctrl_q <= rstb_ctrl_d;
      irq_en_q    <= irq_en_d;
      div_q       <= div_d;
      clear_q     <= clear_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      cnt_q       <= cnt_d;
      clk_m_q     <= clk_m_d;
      k_q         <= k_d;
      word_q      <= word_d;
      rstb_q      <= rstb_ctrl_q;
      ud_out_q    <= ud_en_q;
      irq_q       <= irq_en_q & ~fifo_empty;
    end
  end

endmodule

// File: tb/tb_unison_readout_rx.sv
// Bench for unison_readout_rx: Wishbone driver tasks, a sample driver that
// follows clk_master, a queue-based reference model of the packed words and
// flags, and a monitor that checks every ack against the expected queue.
module tb_unison_readout_rx;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_DATA = 32'h3000_0008;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [1:0]  read_out_I, read_out_Q;
  logic        clk_master, rstb, ud_en, irq;

  unison_readout_rx #(.ADDR_BASE(32'h3000_0000), .DEPTH(DEPTH), .DIV_RST(8'd4)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .read_out_I (read_out_I),
    .read_out_Q (read_out_Q),
    .clk_master (clk_master),
    .rstb       (rstb),
    .ud_en      (ud_en),
    .irq        (irq)
  );

  // Clock
  always #5 wb_clk_i = ~wb_clk_i;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: one entry per issued Wishbone transfer
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       name_q[$];

  // Reference model
  logic [31:0] mq[$];
  bit          m_ovf, m_udf;
  int          nib_cnt;
  logic [31:0] part;
  logic [31:0] ctrl_shadow;

  logic [31:0] mon_e;
  bit          mon_c;
  string       mon_n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {12'b0, m_udf, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), 8'b0, 8'(mq.size())};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    nib_cnt = 0;
    part = '0;
  endtask

  // Each captured nibble lands at position nib_cnt of the word under construction
  task automatic model_nib(input logic [3:0] nib);
    part = part | (32'(nib) << (4 * nib_cnt));
    nib_cnt++;
    if (nib_cnt == 8) begin
      if (mq.size() < DEPTH) mq.push_back(part);
      else m_ovf = 1;
      nib_cnt = 0;
      part = '0;
    end
  endtask

  // Monitor: pop and compare on every ack
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got an ack with nothing pending, required none");
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = chk_q.pop_front();
        mon_n = name_q.pop_front();
        if (mon_c) check(mon_n, wbs_dat_o, mon_e);
      end
    end
  end

  task automatic wb_cycle(input bit we, input logic [31:0] adr, input logic [31:0] dat);
    bit got;
    got = 0;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
    for (int n = 0; n < 20; n++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got = 1;
        break;
      end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got no ack at %h, required one within 20 cycles", adr);
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    exp_q.push_back('0); chk_q.push_back(0); name_q.push_back("write");
    wb_cycle(1, adr, dat);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp); chk_q.push_back(1); name_q.push_back(nm);
    wb_cycle(0, adr, '0);
  endtask

  task automatic read_data(input string nm);
    logic [31:0] e;
    if (mq.size() == 0) begin
      e = '0;
      m_udf = 1;
    end else begin
      e = mq.pop_front();
    end
    wb_read(A_DATA, e, nm);
  endtask

  task automatic set_ctrl(input logic [31:0] v);
    ctrl_shadow = v;
    wb_write(A_CTRL, v);
    nib_cnt = 0;
    part = '0;
  endtask

  // Drive a nibble and wait for the clk_master rising edge that captures it
  task automatic send_sample(input logic [3:0] nib, output int cyc);
    logic prev;
    {read_out_I, read_out_Q} = nib;
    prev = clk_master;
    cyc = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge wb_clk_i); #1;
      cyc++;
      if (!prev && clk_master) break;
      prev = clk_master;
      if (n == 199) begin
        checks++;
        failures++;
        $display("FAIL clk_master_timeout: got no rising edge, required one within 200 cycles");
      end
    end
  endtask

  // mode 0: constant nibble, 1: nibble = index, 2: random
  task automatic send_group(input int nwords, input int mode, input logic [3:0] fixed,
                            input bit chk_period, input int d);
    int cyc;
    logic [3:0] nib;
    for (int w = 0; w < nwords; w++) begin
      for (int i = 0; i < 8; i++) begin
        nib = (mode == 0) ? fixed : (mode == 1) ? 4'(i) : 4'($urandom_range(0, 15));
        send_sample(nib, cyc);
        model_nib(nib);
        if (chk_period && !(w == 0 && i == 0)) check("clk_master_period", 32'(cyc), 32'(2 * d));
      end
    end
  endtask

  initial begin
    int acks;
    int cyc;
    int d_field, d, nw, np, nr;
    logic [3:0] nib;
    wb_rst_i = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 4'hf; wbs_dat_i = '0; wbs_adr_i = '0;
    read_out_I = '0; read_out_Q = '0;
    model_reset();
    ctrl_shadow = 32'h0000_0400;
    repeat (4) @(posedge wb_clk_i);
    #1 wb_rst_i = 0;

    // Reset state
    check("rst_clk_master", 32'(clk_master), 0);
    check("rst_rstb", 32'(rstb), 0);
    check("rst_ud_en", 32'(ud_en), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_ack", 32'(wbs_ack_o), 0);
    check("rst_dat", wbs_dat_o, 0);
    wb_read(A_CTRL, 32'h0000_0400, "rst_ctrl");
    wb_read(A_STAT, 32'h0001_0000, "rst_status");
    wb_read(32'h3000_0010, 32'h0, "unmapped_read");

    // Held strobe gets one ack every two cycles
    exp_q.push_back(ctrl_shadow); chk_q.push_back(1); name_q.push_back("held_rd0");
    exp_q.push_back(ctrl_shadow); chk_q.push_back(1); name_q.push_back("held_rd1");
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = A_CTRL;
    acks = 0;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    check("held_strobe_acks", 32'(acks), 2);

    // No ack outside the window
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_0100;
    acks = 0;
    repeat (3) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    check("out_of_window_acks", 32'(acks), 0);

    // div=2, constant {I,Q}=1001
    set_ctrl(32'h0000_0207);
    check("rstb_in_ack_cycle", 32'(rstb), 0);
    @(posedge wb_clk_i); #1;
    check("rstb_after_ack", 32'(rstb), 1);
    check("ud_en_after_ack", 32'(ud_en), 1);
    send_group(1, 0, 4'b1001, 1, 2);
    set_ctrl(32'h0000_0216);
    @(posedge wb_clk_i); #1;
    check("irq_nonempty", 32'(irq), 1);
    wb_read(A_STAT, model_status(), "status_one_word");
    read_data("data_9999");
    @(posedge wb_clk_i); #1;
    check("irq_empty", 32'(irq), 0);
    wb_read(A_STAT, model_status(), "status_empty");

    // Nibble index pattern
    set_ctrl(32'h0000_0207);
    send_group(1, 1, 4'h0, 0, 2);
    set_ctrl(32'h0000_0206);
    read_data("data_76543210");

    // Overflow: 17 words into 16 slots
    set_ctrl(32'h0000_0207);
    send_group(17, 2, 4'h0, 0, 2);
    set_ctrl(32'h0000_0206);
    wb_read(A_STAT, model_status(), "status_full_ovf");
    for (int i = 0; i < 16; i++) read_data($sformatf("drain_%0d", i));
    wb_write(A_STAT, 32'h0004_0000);
    m_ovf = 0;
    wb_read(A_STAT, model_status(), "status_ovf_cleared");

    // Underflow
    read_data("data_empty");
    wb_read(A_STAT, model_status(), "status_udf");

    // Clear mid-word: flushes FIFO and flags, restarts at nibble 0
    set_ctrl(32'h0000_0207);
    send_group(1, 2, 4'h0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      nib = 4'($urandom_range(0, 15));
      send_sample(nib, cyc);
      model_nib(nib);
    end
    wb_write(A_CTRL, 32'h0000_020F);
    model_reset();
    send_group(1, 2, 4'h0, 0, 2);
    set_ctrl(32'h0000_0206);
    wb_read(A_STAT, model_status(), "status_after_clear");
    wb_read(A_CTRL, ctrl_shadow, "ctrl_clear_reads0");
    read_data("data_after_clear");

    // Reset during a pending DATA read
    set_ctrl(32'h0000_0217);
    send_group(1, 2, 4'h0, 0, 2);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = A_DATA;
    wb_rst_i = 1;
    acks = 0;
    repeat (2) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 0;
    check("reset_read_acks", 32'(acks), 0);
    model_reset();
    ctrl_shadow = 32'h0000_0400;
    check("rst2_clk_master", 32'(clk_master), 0);
    check("rst2_rstb", 32'(rstb), 0);
    check("rst2_irq", 32'(irq), 0);
    wb_read(A_CTRL, 32'h0000_0400, "rst2_ctrl");
    wb_read(A_STAT, 32'h0001_0000, "rst2_status");

    // Randomized rounds, including div=0
    for (int r = 0; r < 5; r++) begin
      d_field = (r == 0) ? 0 : $urandom_range(0, 3);
      d = (d_field == 0) ? 1 : d_field;
      set_ctrl({16'b0, 8'(d_field), 8'h07});
      nw = $urandom_range(1, 3);
      send_group(nw, 2, 4'h0, 1, d);
      np = $urandom_range(0, 6);
      for (int i = 0; i < np; i++) begin
        nib = 4'($urandom_range(0, 15));
        send_sample(nib, cyc);
        model_nib(nib);
      end
      set_ctrl({16'b0, 8'(d_field), 8'h06});
      wb_read(A_STAT, model_status(), $sformatf("rnd%0d_status", r));
      nr = mq.size() + 1;
      for (int i = 0; i < nr; i++) read_data($sformatf("rnd%0d_data%0d", r, i));
      wb_read(A_STAT, model_status(), $sformatf("rnd%0d_status_end", r));
      wb_write(A_STAT, 32'h000C_0000);
      m_ovf = 0;
      m_udf = 0;
    end
    wb_read(A_STAT, model_status(), "final_status");

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge wb_clk_i);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending acks, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
